// File: rtl/mcu_spi_bridge_pkg.sv
// Shared constants for the MCU SPI bridge: target codes, idle MISO byte, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a; the SPI link has no flow control, targets must keep up.
package mcu_spi_pkg;

  // Target codes carried in the first byte after chip select
  localparam logic [7:0] TGT_NONE = 8'd0;
  localparam logic [7:0] TGT_SYS  = 8'd1;
  localparam logic [7:0] TGT_HID  = 8'd2;
  localparam logic [7:0] TGT_OSD  = 8'd3;
  localparam logic [7:0] TGT_SDC  = 8'd5;

  // Byte shifted out on MISO when no valid target is selected
  localparam logic [7:0] IDLE_DOUT_DEF = 8'h00;

  // Transfer state: deselected, expecting target byte, streaming payload
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TARGET  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  // Unknown codes collapse to NONE so later bytes are silently dropped
  function automatic logic [7:0] tgt_decode(input logic [7:0] code);
    case (code)
      TGT_SYS, TGT_HID, TGT_OSD, TGT_SDC: tgt_decode = code;
      default:                            tgt_decode = TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mcu_spi_bridge_if.sv
// Target-side bus of the MCU SPI bridge: shared start/data, per-target strobes and responses.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are one-clk pulses, responses must be ready within 2 clk.
interface mcu_spi_bridge_if;
  logic       mcu_start;
  logic [7:0] mcu_din;
  logic       mcu_sys_strobe;
  logic       mcu_hid_strobe;
  logic       mcu_osd_strobe;
  logic       mcu_sdc_strobe;
  logic [7:0] mcu_sys_dout;
  logic [7:0] mcu_hid_dout;
  logic [7:0] mcu_osd_dout;
  logic [7:0] mcu_sdc_dout;

  // Bridge side
  modport master (
    output mcu_start, mcu_din,
    output mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe,
    input  mcu_sys_dout, mcu_hid_dout, mcu_osd_dout, mcu_sdc_dout
  );

  // Command target side
  modport slave (
    input  mcu_start, mcu_din,
    input  mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe,
    output mcu_sys_dout, mcu_hid_dout, mcu_osd_dout, mcu_sdc_dout
  );
endinterface

// File: rtl/mcu_spi_bridge_spi_sync_edge.sv
// N-stage synchroniser with rise/fall detection on the synchronised signal.
// Latency: STAGES clk to the synchronised sample; edge flags are combinational from it.
// Backpressure: none.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              last;

  // Shift the pin through the chain; keep one extra sample for edge compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RST_VAL}};
      last  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      last  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~last;
  assign fall = ~chain[STAGES-1] & last;
endmodule

// File: rtl/mcu_spi_bridge.sv
// SPI mode-0 slave that demultiplexes MCU bytes to sys/hid/osd/sdc targets and returns their responses.
// Latency: strobe 1 clk after the clk that sees the 8th synchronised SCK rise; response shifts out on the next byte.
// Backpressure: none; core clk >= 8x SCK lets targets answer within 2 clk of their strobe.
module mcu_spi_bridge
  import mcu_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_DOUT   = IDLE_DOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_io_ss,
  input  logic             spi_io_clk,
  input  logic             spi_io_din,
  output logic             spi_io_dout,
  mcu_spi_bridge_if.master mcu
);
  logic [SYNC_STAGES-1:0] ss_chain;
  logic [SYNC_STAGES-1:0] din_chain;
  logic                   ss_s;
  logic                   din_s;
  logic                   sck_rise;
  logic                   sck_fall;

  logic [1:0] state;
  logic [2:0] bitcnt;
  logic [1:0] bytecnt;
  logic [7:0] rx;
  logic [7:0] tx;
  logic [7:0] target;
  logic       byte_done;  // a full byte sits in rx, handle it this clk
  logic       load_pend;  // next SCK fall loads the target response into tx
  logic       dout_en;    // holds MISO low until the first clk out of reset
  logic [3:0] stb_q;      // {sdc, osd, hid, sys}
  logic       start_q;
  logic [7:0] din_q;

  logic [7:0] resp;
  logic [3:0] tgt_onehot;

  // Chip select and MOSI only need to be synchronised, no edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_chain  <= {SYNC_STAGES{1'b1}};
      din_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      ss_chain  <= {ss_chain[SYNC_STAGES-2:0], spi_io_ss};
      din_chain <= {din_chain[SYNC_STAGES-2:0], spi_io_din};
    end
  end

  assign ss_s  = ss_chain[SYNC_STAGES-1];
  assign din_s = din_chain[SYNC_STAGES-1];

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sck_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_io_clk),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  // Select the latched target's response byte and strobe line
  always_comb begin
    resp       = IDLE_DOUT;
    tgt_onehot = 4'b0000;
    case (target)
      TGT_SYS: begin resp = mcu.mcu_sys_dout; tgt_onehot = 4'b0001; end
      TGT_HID: begin resp = mcu.mcu_hid_dout; tgt_onehot = 4'b0010; end
      TGT_OSD: begin resp = mcu.mcu_osd_dout; tgt_onehot = 4'b0100; end
      TGT_SDC: begin resp = mcu.mcu_sdc_dout; tgt_onehot = 4'b1000; end
      default: begin resp = IDLE_DOUT;        tgt_onehot = 4'b0000; end
    endcase
  end

  // Bit/byte framing, target dispatch and MISO shifting; deselect overrides everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bitcnt    <= 3'd0;
      bytecnt   <= 2'd0;
      rx        <= 8'h00;
      tx        <= IDLE_DOUT;
      target    <= TGT_NONE;
      byte_done <= 1'b0;
      load_pend <= 1'b0;
      dout_en   <= 1'b0;
      stb_q     <= 4'b0000;
      start_q   <= 1'b0;
      din_q     <= 8'h00;
    end else begin
      dout_en <= 1'b1;
      stb_q   <= 4'b0000;
      start_q <= 1'b0;
      if (ss_s) begin
        state     <= ST_IDLE;
        bitcnt    <= 3'd0;
        bytecnt   <= 2'd0;
        target    <= TGT_NONE;
        byte_done <= 1'b0;
        load_pend <= 1'b0;
        tx        <= IDLE_DOUT;
      end else begin
        if (state == ST_IDLE) begin
          state <= ST_TARGET;
        end
        if (sck_rise) begin
          rx     <= {rx[6:0], din_s};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            byte_done <= 1'b1;
          end
        end else if (sck_fall) begin
          if (load_pend) begin
            tx        <= resp;
            load_pend <= 1'b0;
          end else begin
            tx <= {tx[6:0], 1'b0};
          end
        end
        if (byte_done) begin
          byte_done <= 1'b0;
          load_pend <= 1'b1;
          if (state == ST_PAYLOAD) begin
            din_q   <= rx;
            stb_q   <= tgt_onehot;
            start_q <= (bytecnt == 2'd1) && (target != TGT_NONE);
            if (bytecnt != 2'd2) begin
              bytecnt <= bytecnt + 2'd1;
            end
          end else begin
            target  <= tgt_decode(rx);
            bytecnt <= 2'd1;
            state   <= ST_PAYLOAD;
          end
        end
      end
    end
  end

  assign spi_io_dout        = dout_en & tx[7];
  assign mcu.mcu_start      = start_q;
  assign mcu.mcu_din        = din_q;
  assign mcu.mcu_sys_strobe = stb_q[0];
  assign mcu.mcu_hid_strobe = stb_q[1];
  assign mcu.mcu_osd_strobe = stb_q[2];
  assign mcu.mcu_sdc_strobe = stb_q[3];
endmodule

// File: tb/tb_mcu_spi_bridge.sv
// Self-checking bench for mcu_spi_bridge: MCU-side SPI driver, target responders, transfer-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mcu_spi_bridge;
  localparam logic [7:0] IDLE = 8'h00;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic spi_io_ss  = 1'b1;
  logic spi_io_clk = 1'b0;
  logic spi_io_din = 1'b0;
  logic spi_io_dout;

  mcu_spi_bridge_if bus ();

  mcu_spi_bridge #(
    .SYNC_STAGES (2),
    .IDLE_DOUT   (IDLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_io_ss   (spi_io_ss),
    .spi_io_clk  (spi_io_clk),
    .spi_io_din  (spi_io_din),
    .spi_io_dout (spi_io_dout),
    .mcu         (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] m;
    logic       s;
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] resp_mem [0:3][0:63];
  logic [5:0] rcnt [0:3];
  int         mcnt [0:3];
  logic [7:0] xb [0:15];
  logic [7:0] miso_got [0:15];
  int         n_checks = 0;
  int         n_errors = 0;

  // Each target presents resp_mem[t][number of strobes it has seen]
  assign bus.mcu_sys_dout = resp_mem[0][rcnt[0]];
  assign bus.mcu_hid_dout = resp_mem[1][rcnt[1]];
  assign bus.mcu_osd_dout = resp_mem[2][rcnt[2]];
  assign bus.mcu_sdc_dout = resp_mem[3][rcnt[3]];

  // Target responders: advance their response pointer on each strobe
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rcnt[i] <= 6'd0;
    end else begin
      if (bus.mcu_sys_strobe) rcnt[0] <= rcnt[0] + 6'd1;
      if (bus.mcu_hid_strobe) rcnt[1] <= rcnt[1] + 6'd1;
      if (bus.mcu_osd_strobe) rcnt[2] <= rcnt[2] + 6'd1;
      if (bus.mcu_sdc_strobe) rcnt[3] <= rcnt[3] + 6'd1;
    end
  end

  // Record every clk on which any strobe is high
  always @(negedge clk) begin
    if (!reset && (bus.mcu_sys_strobe | bus.mcu_hid_strobe | bus.mcu_osd_strobe | bus.mcu_sdc_strobe))
      evq.push_back('{m: {bus.mcu_sdc_strobe, bus.mcu_osd_strobe, bus.mcu_hid_strobe, bus.mcu_sys_strobe},
                      s: bus.mcu_start, d: bus.mcu_din});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int tgt_idx(input logic [7:0] code);
    case (code)
      8'd1:    return 0;
      8'd2:    return 1;
      8'd3:    return 2;
      8'd5:    return 3;
      default: return -1;
    endcase
  endfunction

  // MCU side: shift nbits of b MSB first, sampling MISO just before each rise
  task automatic spi_bits(input logic [7:0] b, input int nbits, input int hp, output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_io_din = b[7-i];
      repeat (hp) @(negedge clk);
      m = {m[6:0], spi_io_dout};
      spi_io_clk = 1'b1;
      repeat (hp) @(negedge clk);
      spi_io_clk = 1'b0;
    end
  endtask

  // Select, send xb[0..n-1] (last one possibly partial), optionally deselect
  task automatic run_xfer(input int n, input int last_bits, input int hp, input bit deselect);
    logic [7:0] m;
    spi_io_ss = 1'b0;
    repeat (hp) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      spi_bits(xb[k], (k == n - 1) ? last_bits : 8, hp, m);
      miso_got[k] = m;
    end
    repeat (hp) @(negedge clk);
    if (deselect) spi_io_ss = 1'b1;
  endtask

  // Transfer-level expectations: byte 0 picks the target, each later byte
  // strobes it once; MISO byte k carries the response after k-1 strobes.
  task automatic check_xfer(input string tag, input int n_full);
    int         t;
    int         n_exp;
    ev_t        e;
    logic [7:0] exp_m;
    t     = (n_full > 0) ? tgt_idx(xb[0]) : -1;
    n_exp = (t >= 0 && n_full > 1) ? n_full - 1 : 0;
    check({tag, "_nstrobe"}, evq.size(), n_exp);
    for (int k = 1; k < n_full; k++) begin
      if (t >= 0 && evq.size() > 0) begin
        e = evq.pop_front();
        check({tag, "_mask"},  e.m, 32'd1 << t);
        check({tag, "_start"}, e.s, (k == 1) ? 1 : 0);
        check({tag, "_din"},   e.d, xb[k]);
      end
    end
    for (int k = 0; k < n_full; k++) begin
      exp_m = (k == 0 || t < 0) ? IDLE : resp_mem[t][(mcnt[t] + k - 1) % 64];
      check({tag, "_miso"}, miso_got[k], exp_m);
    end
    if (n_exp > 0) mcnt[t] = mcnt[t] + n_exp;
    evq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] codes [0:3];
    int         c;
    int         n;
    int         r;
    codes[0] = 8'd1; codes[1] = 8'd2; codes[2] = 8'd3; codes[3] = 8'd5;
    for (int t = 0; t < 4; t++) begin
      mcnt[t] = 0;
      for (int i = 0; i < 64; i++) resp_mem[t][i] = 8'($urandom_range(0, 255));
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", {bus.mcu_sdc_strobe, bus.mcu_osd_strobe, bus.mcu_hid_strobe, bus.mcu_sys_strobe}, 0);
    check("rst_start", bus.mcu_start, 0);
    check("rst_din", bus.mcu_din, 0);
    check("rst_dout", spi_io_dout, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a payload byte
    xb[0] = 8'h01; xb[1] = 8'hA5; xb[2] = 8'h3C;
    run_xfer(3, 4, 4, 1'b0);
    check_xfer("pre_rst", 2);
    reset = 1'b1;
    #1;
    check("mid_rst_strobes", {bus.mcu_sdc_strobe, bus.mcu_osd_strobe, bus.mcu_hid_strobe, bus.mcu_sys_strobe}, 0);
    check("mid_rst_start", bus.mcu_start, 0);
    check("mid_rst_din", bus.mcu_din, 0);
    check("mid_rst_dout", spi_io_dout, 0);
    spi_io_ss = 1'b1; spi_io_clk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 4; t++) mcnt[t] = 0;
    evq.delete();
    repeat (4) @(negedge clk);
    xb[0] = 8'h01; xb[1] = 8'h00;
    run_xfer(2, 8, 5, 1'b1);
    repeat (6) @(negedge clk);
    check_xfer("post_rst", 2);

    // SYS command with dummy bytes; responses 00 00 5c 42 00
    c = mcnt[0];
    resp_mem[0][(c + 0) % 64] = 8'h00;
    resp_mem[0][(c + 1) % 64] = 8'h00;
    resp_mem[0][(c + 2) % 64] = 8'h5C;
    resp_mem[0][(c + 3) % 64] = 8'h42;
    resp_mem[0][(c + 4) % 64] = 8'h00;
    xb[0] = 8'h01; xb[1] = 8'h00;
    for (int k = 2; k < 5; k++) xb[k] = 8'($urandom_range(0, 255));
    run_xfer(5, 8, 4, 1'b1);
    repeat (6) @(negedge clk);
    check_xfer("sys", 5);
    check("sys_miso3", miso_got[3], 8'h5C);
    check("sys_miso4", miso_got[4], 8'h42);

    // Invalid target code
    xb[0] = 8'h04;
    for (int k = 1; k < 4; k++) xb[k] = 8'($urandom_range(0, 255));
    run_xfer(4, 8, 5, 1'b1);
    repeat (6) @(negedge clk);
    check_xfer("invalid", 4);

    // Deselect after 5 bits of the target byte, then a clean HID transfer
    xb[0] = 8'h02;
    run_xfer(1, 5, 4, 1'b1);
    repeat (6) @(negedge clk);
    check_xfer("partial", 0);
    xb[0] = 8'h02; xb[1] = 8'h07;
    run_xfer(2, 8, 4, 1'b1);
    repeat (6) @(negedge clk);
    check_xfer("hid", 2);

    // SDC with 5 payload bytes at the fastest SCK
    xb[0] = 8'h05;
    for (int k = 1; k < 6; k++) xb[k] = 8'($urandom_range(0, 255));
    run_xfer(6, 8, 4, 1'b1);
    repeat (6) @(negedge clk);
    check_xfer("sdc", 6);

    // OSD then SYS with chip select high for only 2 clk in between
    xb[0] = 8'h03; xb[1] = 8'h11; xb[2] = 8'h22;
    run_xfer(3, 8, 4, 1'b1);
    check_xfer("osd", 3);
    repeat (2) @(negedge clk);
    xb[0] = 8'h01; xb[1] = 8'h33; xb[2] = 8'h44; xb[3] = 8'h55;
    run_xfer(4, 8, 4, 1'b1);
    repeat (6) @(negedge clk);
    check_xfer("b2b_sys", 4);

    // Random transfers: mostly valid targets, some random codes
    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(0, 5);
      xb[0] = (r < 4) ? codes[r] : 8'($urandom_range(0, 255));
      n = $urandom_range(1, 6);
      for (int k = 1; k < n; k++) xb[k] = 8'($urandom_range(0, 255));
      run_xfer(n, 8, $urandom_range(4, 7), 1'b1);
      repeat ($urandom_range(2, 8)) @(negedge clk);
      check_xfer("rand", n);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mcu_spi_bridge.md
Name: mcu_spi_bridge

Overview:
- SPI slave (mode 0, MSB first) that terminates the MCU link and demultiplexes its byte stream to the on-chip command targets: system control, HID, OSD and SD card.
- Sits directly upstream of the system-control block. It produces the per-target byte strobe, the shared start flag and the shared data byte, and it returns the selected target's response byte on MISO.
- All SPI pins are oversampled in the core clock domain; no SPI clock is used as a clock.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronisers on spi_io_ss, spi_io_clk and spi_io_din (minimum 2).
- IDLE_DOUT, 8'h00, byte shifted out when no valid target is selected.

Ports:
- clk  in  1  core clock; must be at least 8x the SPI clock.
- reset  in  1  asynchronous, active-high reset.
- spi_io_ss  in  1  MCU chip select, active low.
- spi_io_clk  in  1  SPI clock from the MCU.
- spi_io_din  in  1  MOSI.
- spi_io_dout  out  1  MISO; the external pad handles tristate.
- mcu_start  out  1  marks the first payload byte (command byte); valid together with a strobe.
- mcu_din  out  8  payload byte, shared by all targets; valid together with a strobe.
- mcu_sys_strobe / mcu_hid_strobe / mcu_osd_strobe / mcu_sdc_strobe  out  1 each  one-clk strobe to the addressed target.
- mcu_sys_dout / mcu_hid_dout / mcu_osd_dout / mcu_sdc_dout  in  8 each  target response bytes.

Behaviour:
- Reset (async):
  - All strobes 0, mcu_start 0, mcu_din 0.
  - spi_io_dout 0; tx shift register = IDLE_DOUT.
  - Bit counter 0, byte counter 0, target = NONE.
  - Synchronisers: ss chain to 1, clk and din chains to 0.
- Edge detection: compare the last two synchronised samples of spi_io_clk. Rise = 0→1, fall = 1→0. Edges are ignored while synchronised ss is high.
- Deselect (synchronised ss high):
  - Bit counter, byte counter and target return to 0/NONE.
  - Any partial byte is discarded and no strobe is issued.
  - tx = IDLE_DOUT.
  - This applies even mid-byte.
- Receive: on each rise, rx <= {rx[6:0], din}; bitcnt increments modulo 8. On the rise that completes bit 7, the byte is complete; its handling is evaluated the next clk.
- Byte 0 after select:
  - Latched as the target code: SYS=1, HID=2, OSD=3, SDC=5.
  - Any other value gives NONE.
  - No strobe is issued.
- Byte 1 and later:
  - mcu_din <= byte.
  - Exactly one strobe is high for exactly one clk: the one for the latched target, or none if NONE.
  - mcu_start = 1 only for byte 1; otherwise 0.
  - The byte counter saturates at 2.
- Latency: strobe rises 1 clk after the clk that detected the 8th rise.
- Transmit:
  - spi_io_dout = tx[7] continuously.
  - On a fall that follows a completed byte, tx <= muxed dout of the latched target (IDLE_DOUT if NONE).
  - On every other fall, tx <= {tx[6:0], 1'b0}.
  - The MCU therefore receives a target's response to byte N during byte N+1.
  - The target must present dout within 2 clk of its strobe; the 8x clock ratio guarantees this.
- Simultaneous events:
  - A ss rise in the same clk as byte completion means deselect wins: no strobe.
  - Fall and rise cannot coincide under the clock-ratio rule; if they do, rise is processed and fall is ignored.
- State machine: IDLE (ss high) → TARGET (byte 0) → PAYLOAD (bytes 1..n). Any ss high returns to IDLE.
- Widths: bitcnt 3 bits wrapping 7→0; bytecnt 2 bits saturating.

Decomposition:
- Shared package mcu_spi_pkg:
  - target codes TGT_NONE / TGT_SYS=8'd1 / TGT_HID=8'd2 / TGT_OSD=8'd3 / TGT_SDC=8'd5
  - IDLE_DOUT default
  - state enum IDLE / TARGET / PAYLOAD
- One natural sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall detector, instantiated for clk. ss and din use the synchroniser only.

Test Plan:
- Reset mid-byte: assert reset after 4 bits → all outputs 0 immediately (async), no strobe. After release, a fresh transfer of 01 00 works.
- Target SYS, command 0x00, then 3 dummy bytes, with a sys model returning 5c, 42, 00 on successive strobes → mcu_sys_strobe pulses 4 times; mcu_start=1 only on the first pulse with mcu_din=00; MISO bytes read 00, 00, 00, 5c, 42.
- Target 0x04 (invalid) followed by 3 bytes → no strobe on any target; MISO = IDLE_DOUT for every byte.
- Deselect after 5 bits of the command byte, then reselect and send 02 07 → no strobe for the partial byte; mcu_hid_strobe once with mcu_start=1 and mcu_din=07.
- SDC target with 5 payload bytes at sclk = clk/8 (the limit) → 5 strobes; mcu_start only on the first; each response byte appears exactly one byte later on MISO.
- Back-to-back transfers to OSD then SYS with ss high for 2 clk between them → target relatched; no strobe leaks to OSD during the SYS transfer.
